// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake/control bundle between the LC-3b pipeline datapath and pipe_hazard_ctrl.
// slave = the hazard controller, master = the datapath side that feeds it.
interface pipe_hazard_ctrl_if #(
  parameter int NUM_LATCH = 4,
  parameter int REG_W     = 3
);
  logic                 imem_read;
  logic                 imem_resp;
  logic                 mem_op;
  logic                 mem_resp;
  logic                 branch_taken;
  logic [REG_W-1:0]     id_sr1;
  logic [REG_W-1:0]     id_sr2;
  logic                 id_sr1_use;
  logic                 id_sr2_use;
  logic [REG_W-1:0]     ex_dr;
  logic                 ex_is_load;
  logic                 pc_load;
  logic                 pc_sel;
  logic [NUM_LATCH-1:0] latch_load;
  logic [NUM_LATCH-1:0] latch_vin;
  logic [NUM_LATCH-1:0] valid_q;

  modport master (
    output imem_resp, mem_op, mem_resp, branch_taken,
           id_sr1, id_sr2, id_sr1_use, id_sr2_use, ex_dr, ex_is_load,
    input  imem_read, pc_load, pc_sel, latch_load, latch_vin, valid_q
  );

  modport slave (
    input  imem_resp, mem_op, mem_resp, branch_taken,
           id_sr1, id_sr2, id_sr1_use, id_sr2_use, ex_dr, ex_is_load,
    output imem_read, pc_load, pc_sel, latch_load, latch_vin, valid_q
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/valid controller for the pipelined LC-3b core.
// Optional macro PERF_CNT_EN adds saturating stall_cycles / flush_events counters.
module pipe_hazard_ctrl #(
  parameter int NUM_LATCH = 4,
  parameter int MEM_IDX   = 2,
  parameter int BR_IDX    = 2,
  parameter int REG_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  pipe_hazard_ctrl_if.slave     hz
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_events
`endif
);

  typedef enum logic {F_RUN, F_KILL} fetch_state_t;

  localparam logic [NUM_LATCH-1:0] BIT0  = {{(NUM_LATCH-1){1'b0}}, 1'b1};
  localparam logic [NUM_LATCH-1:0] BIT01 = {{(NUM_LATCH-2){1'b0}}, 2'b11};

  fetch_state_t         state;
  fetch_state_t         state_nxt;
  logic [NUM_LATCH-1:0] valid;
  logic [NUM_LATCH-1:0] prev_valid;
  logic [NUM_LATCH-1:0] load;
  logic [NUM_LATCH-1:0] vin;
  logic                 pc_load;
  logic                 pc_sel;
  logic                 imem_read;
  logic [REG_W-1:0]     sr1;
  logic [REG_W-1:0]     sr2;
  logic [REG_W-1:0]     dr;
  logic                 src_hit;
  logic                 dstall;
  logic                 br;
  logic                 lu;
  logic                 fstall;

  assign sr1 = hz.id_sr1;
  assign sr2 = hz.id_sr2;
  assign dr  = hz.ex_dr;

  // Valid bit each latch would receive on a plain advance; latch 0 always gets a fresh fetch
  assign prev_valid = {valid[NUM_LATCH-2:0], 1'b1};

  assign src_hit = (hz.id_sr1_use & (sr1 == dr)) | (hz.id_sr2_use & (sr2 == dr));
  assign dstall  = valid[MEM_IDX] & hz.mem_op & ~hz.mem_resp;
  assign br      = valid[BR_IDX] & hz.branch_taken & ~dstall;
  assign lu      = valid[0] & valid[1] & hz.ex_is_load & src_hit & ~dstall & ~br;
  assign fstall  = ~hz.imem_resp & ~dstall & ~br & ~lu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= F_RUN;
      valid <= '0;
    end else begin
      state <= state_nxt;
      valid <= (valid & ~load) | (vin & load);
    end
  end

  always_comb begin
    state_nxt = state;
    load      = '0;
    vin       = '0;
    pc_load   = 1'b0;
    pc_sel    = 1'b0;
    imem_read = 1'b0;
    if (!rst) begin
      imem_read = 1'b1;
      if (dstall) begin
        for (int k = MEM_IDX + 1; k < NUM_LATCH; k++) begin
          load[k] = 1'b1;
          vin[k]  = (k == MEM_IDX + 1) ? 1'b0 : prev_valid[k];
        end
      end else if (br) begin
        pc_load = 1'b1;
        pc_sel  = 1'b1;
        load    = '1;
        for (int k = 0; k < NUM_LATCH; k++) begin
          vin[k] = (k > BR_IDX) ? prev_valid[k] : 1'b0;
        end
      end else if (lu) begin
        load = ~BIT0;
        vin  = prev_valid & ~BIT01;
      end else if (fstall || state == F_KILL) begin
        // In F_KILL any arriving response belongs to the pre-redirect PC, so it is dropped
        load = '1;
        vin  = prev_valid & ~BIT0;
      end else begin
        load    = '1;
        vin     = prev_valid;
        pc_load = 1'b1;
      end

      if (br) begin
        state_nxt = hz.imem_resp ? F_RUN : F_KILL;
      end else if (state == F_KILL && hz.imem_resp) begin
        state_nxt = F_RUN;
      end
    end
  end

  assign hz.imem_read  = imem_read;
  assign hz.pc_load    = pc_load;
  assign hz.pc_sel     = pc_sel;
  assign hz.latch_load = load;
  assign hz.latch_vin  = vin;
  assign hz.valid_q    = valid;

`ifdef PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if ((dstall | lu | fstall) && stall_cycles != 32'hFFFF_FFFF) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (br && flush_events != 32'hFFFF_FFFF) begin
        flush_events <= flush_events + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios then random traffic
// compared against a stage-by-stage behavioural model of the stall/flush rules.
module tb_pipe_hazard_ctrl;

  localparam int NL   = 4;
  localparam int MEM  = 2;
  localparam int BR   = 2;
  localparam int RW   = 3;

  logic clk;
  logic rst;

  pipe_hazard_ctrl_if #(.NUM_LATCH(NL), .REG_W(RW)) hz ();

`ifdef PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;
`endif

  pipe_hazard_ctrl #(
    .NUM_LATCH (NL),
    .MEM_IDX   (MEM),
    .BR_IDX    (BR),
    .REG_W     (RW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .hz           (hz)
`ifdef PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model state: one valid flag per latch plus "stale fetch in flight"
  bit          m_valid [NL];
  bit          m_kill;
  bit          m_kill_nxt;
  int unsigned m_stall;
  int unsigned m_flush;
  bit          m_inc_stall;
  bit          m_inc_flush;

  logic [NL-1:0] exp_load;
  logic [NL-1:0] exp_vin;
  logic          exp_pcl;
  logic          exp_pcs;

  logic [NL-1:0] obs_load;
  logic [NL-1:0] obs_vin;
  logic          obs_pcl;
  logic          obs_pcs;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [NL-1:0] model_valid_vec();
    logic [NL-1:0] v;
    for (int k = 0; k < NL; k++) v[k] = m_valid[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NL; k++) m_valid[k] = 1'b0;
    m_kill  = 1'b0;
    m_stall = 0;
    m_flush = 0;
  endtask

  // Decide which latches freeze, which receive a bubble, and what the PC does
  task automatic model_eval();
    bit ds, brr, luh, hit;
    int hold_top;
    bit bub [NL];
    hold_top = -1;
    for (int k = 0; k < NL; k++) bub[k] = 1'b0;
    exp_pcl     = 1'b0;
    exp_pcs     = 1'b0;
    m_inc_stall = 1'b0;
    m_inc_flush = 1'b0;

    hit = (hz.id_sr1_use && hz.id_sr1 == hz.ex_dr) || (hz.id_sr2_use && hz.id_sr2 == hz.ex_dr);
    ds  = m_valid[MEM] && hz.mem_op && !hz.mem_resp;
    brr = !ds && m_valid[BR] && hz.branch_taken;
    luh = !ds && !brr && m_valid[0] && m_valid[1] && hz.ex_is_load && hit;

    if (ds) begin
      hold_top      = MEM;
      bub[MEM + 1]  = 1'b1;
      m_inc_stall   = 1'b1;
    end else if (brr) begin
      for (int k = 0; k <= BR; k++) bub[k] = 1'b1;
      exp_pcl     = 1'b1;
      exp_pcs     = 1'b1;
      m_inc_flush = 1'b1;
    end else if (luh) begin
      hold_top    = 0;
      bub[1]      = 1'b1;
      m_inc_stall = 1'b1;
    end else if (!hz.imem_resp || m_kill) begin
      bub[0]      = 1'b1;
      m_inc_stall = !hz.imem_resp;
    end else begin
      exp_pcl = 1'b1;
    end

    for (int k = 0; k < NL; k++) begin
      exp_load[k] = (k > hold_top);
      if (k == 0) exp_vin[k] = exp_load[k] && !bub[k];
      else        exp_vin[k] = exp_load[k] && !bub[k] && m_valid[k-1];
    end

    if (brr)                        m_kill_nxt = !hz.imem_resp;
    else if (m_kill && hz.imem_resp) m_kill_nxt = 1'b0;
    else                            m_kill_nxt = m_kill;
  endtask

  task automatic model_advance();
    for (int k = 0; k < NL; k++) begin
      if (exp_load[k]) m_valid[k] = exp_vin[k];
    end
    m_kill = m_kill_nxt;
    if (m_inc_stall && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (m_inc_flush && m_flush != 32'hFFFF_FFFF) m_flush++;
  endtask

  task automatic applyStimulus(input bit resp, input bit mop, input bit mresp, input bit bt,
                               input bit ld, input logic [RW-1:0] dr,
                               input logic [RW-1:0] s1, input bit u1,
                               input logic [RW-1:0] s2, input bit u2);
    hz.imem_resp    = resp;
    hz.mem_op       = mop;
    hz.mem_resp     = mresp;
    hz.branch_taken = bt;
    hz.ex_is_load   = ld;
    hz.ex_dr        = dr;
    hz.id_sr1       = s1;
    hz.id_sr1_use   = u1;
    hz.id_sr2       = s2;
    hz.id_sr2_use   = u2;
  endtask

  // One clock: compare combinational outputs mid-cycle, then registered state after the edge
  task automatic run_cycle();
    @(negedge clk);
    model_eval();
    obs_load = hz.latch_load;
    obs_vin  = hz.latch_vin;
    obs_pcl  = hz.pc_load;
    obs_pcs  = hz.pc_sel;
    checkOutput("latch_load", {28'd0, obs_load}, {28'd0, exp_load});
    checkOutput("latch_vin",  {28'd0, obs_vin},  {28'd0, exp_vin});
    checkOutput("pc_load",    {31'd0, obs_pcl},  {31'd0, exp_pcl});
    checkOutput("pc_sel",     {31'd0, obs_pcs},  {31'd0, exp_pcs});
    checkOutput("imem_read",  {31'd0, hz.imem_read}, 32'd1);
    @(posedge clk);
    #1;
    model_advance();
    checkOutput("valid_q", {28'd0, hz.valid_q}, {28'd0, model_valid_vec()});
`ifdef PERF_CNT_EN
    checkOutput("stall_cycles", stall_cycles, m_stall);
    checkOutput("flush_events", flush_events, m_flush);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    checkOutput("rst_valid_q",    {28'd0, hz.valid_q},    32'd0);
    checkOutput("rst_latch_load", {28'd0, hz.latch_load}, 32'd0);
    checkOutput("rst_pc_load",    {31'd0, hz.pc_load},    32'd0);
    checkOutput("rst_imem_read",  {31'd0, hz.imem_read},  32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic normal_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1, 0, 1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0);
      run_cycle();
    end
  endtask

  initial begin
    logic [NL-1:0] fill_exp [4];
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0);
    #3;
    do_reset();

    // Steady fetch fills the pipe
    fill_exp[0] = 4'b0001; fill_exp[1] = 4'b0011; fill_exp[2] = 4'b0111; fill_exp[3] = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      normal_cycles(1);
      if (i == 0) begin
        checkOutput("first_load", {28'd0, obs_load}, 32'hF);
        checkOutput("first_vin",  {28'd0, obs_vin},  32'h1);
      end
      checkOutput("fill_valid", {28'd0, hz.valid_q}, {28'd0, fill_exp[i]});
      checkOutput("fill_pcl",   {31'd0, obs_pcl}, 32'd1);
    end

    // Data-memory wait for three cycles
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0);
      run_cycle();
      checkOutput("dstall_load", {28'd0, obs_load}, 32'h8);
      checkOutput("dstall_vin3", {31'd0, obs_vin[3]}, 32'd0);
      checkOutput("dstall_pcl",  {31'd0, obs_pcl}, 32'd0);
    end
`ifdef PERF_CNT_EN
    checkOutput("perf_stall3", stall_cycles, 32'd3);
    checkOutput("perf_flush0", flush_events, 32'd0);
`endif
    applyStimulus(1, 1, 1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0);
    run_cycle();
    checkOutput("dstall_release", {28'd0, obs_load}, 32'hF);

    // Load-use on sr1
    applyStimulus(1, 0, 1, 0, 1, 3'd3, 3'd3, 1, 3'd0, 0);
    run_cycle();
    checkOutput("lu_pcl",  {31'd0, obs_pcl},    32'd0);
    checkOutput("lu_load", {28'd0, obs_load},   32'hE);
    checkOutput("lu_vin1", {31'd0, obs_vin[1]}, 32'd0);
    normal_cycles(1);
    checkOutput("lu_after", {28'd0, obs_load}, 32'hF);
    normal_cycles(1);
    checkOutput("pre_br_v2", {31'd0, hz.valid_q[2]}, 32'd1);

    // Taken branch while fetch is outstanding, then the stale response
    applyStimulus(0, 0, 1, 1, 0, 3'd0, 3'd0, 0, 3'd0, 0);
    run_cycle();
    checkOutput("br_pcl",  {31'd0, obs_pcl}, 32'd1);
    checkOutput("br_pcs",  {31'd0, obs_pcs}, 32'd1);
    checkOutput("br_vin",  {29'd0, obs_vin[2:0]}, 32'd0);
    normal_cycles(1);
    checkOutput("kill_vin0", {31'd0, obs_vin[0]}, 32'd0);
    checkOutput("kill_pcl",  {31'd0, obs_pcl},    32'd0);
    normal_cycles(1);
    checkOutput("post_kill_vin0", {31'd0, obs_vin[0]}, 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 9) < 6,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 1) != 0, 3'($urandom_range(0, 3)),
                    3'($urandom_range(0, 3)), $urandom_range(0, 1) != 0,
                    3'($urandom_range(0, 3)), $urandom_range(0, 1) != 0);
      run_cycle();
    end

    // Refill then reset asynchronously mid-cycle
    normal_cycles(5);
    checkOutput("prereset_valid", {28'd0, hz.valid_q}, 32'hF);
    do_reset();
    normal_cycles(1);
    checkOutput("postreset_load", {28'd0, obs_load}, 32'hF);
    checkOutput("postreset_vin",  {28'd0, obs_vin},  32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/valid controller for the pipelined LC-3b core.
- Drives the load enables and valid bits of all inter-stage latches (IF/ID … MEM/SR), the PC load/select, and the imem fetch request.
- Resolves imem wait, dmem wait, load-use hazards and taken branches. Redirects issued while a fetch is in flight are handled by discarding the stale fetch.
- Parametrised in stage count and branch-resolve position so deeper pipelines reuse it unchanged.

Parameters:
- NUM_LATCH, 4, number of inter-stage latches. Latch 0 = IF/ID, latch NUM_LATCH-1 = last before writeback. Legal range 3..8.
- MEM_IDX, 2, index of the latch feeding the data-memory stage. Must be < NUM_LATCH-1.
- BR_IDX, 2, index of the latch whose instruction resolves branches. Must be ≤ MEM_IDX and ≥ 1.
- REG_W, 3, register-id width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- imem_resp  in  1  fetch data valid this cycle
- mem_op  in  1  instruction in latch MEM_IDX performs a data-memory access
- mem_resp  in  1  data-memory access complete
- branch_taken  in  1  instruction in latch BR_IDX redirects the PC
- id_sr1, id_sr2  in  REG_W each  sources of the instruction in latch 0
- id_sr1_use, id_sr2_use  in  1 each  source actually read
- ex_dr  in  REG_W  destination of the instruction in latch 1
- ex_is_load  in  1  instruction in latch 1 is a load writing ex_dr
- imem_read  out  1  fetch request
- pc_load  out  1  load PC this cycle
- pc_sel  out  1  0 = PC+2, 1 = branch target
- latch_load  out  NUM_LATCH  per-latch load enable
- latch_vin  out  NUM_LATCH  valid bit written into each latch when loaded (0 = bubble)
- valid_q  out  NUM_LATCH  registered valid bit of each latch

Behaviour:
- Reset (async): valid_q=0, fetch FSM=F_RUN. While rst=1: latch_load=0, pc_load=0, imem_read=0. From the first cycle after deassert: imem_read=1.
- dstall = valid_q[MEM_IDX] & mem_op & ~mem_resp.
  - Latches 0..MEM_IDX hold (load=0); PC holds.
  - Latch MEM_IDX+1 loads with vin=0.
  - Latches above MEM_IDX+1 load normally.
  - Highest priority: overrides branch, load-use and fetch stall.
- br = valid_q[BR_IDX] & branch_taken & ~dstall.
  - pc_load=1, pc_sel=1.
  - Latches 0..BR_IDX load with vin=0; all other latches advance.
  - If imem_resp=0 that cycle, FSM → F_KILL.
- lu = valid_q[0] & valid_q[1] & ex_is_load & ((id_sr1_use & id_sr1==ex_dr) | (id_sr2_use & id_sr2==ex_dr)), applied only when ~dstall & ~br.
  - PC and latch 0 hold.
  - Latch 1 loads with vin=0; latches ≥2 advance.
- Fetch stall (imem_resp=0, no dstall/br/lu):
  - PC holds.
  - Latch 0 loads with vin=0; others advance.
- Normal: all latches load, vin propagates valid_q of the previous latch, latch 0 vin=1, pc_load=1, pc_sel=0.
- Fetch FSM:
  - F_RUN: as above.
  - F_KILL: the next imem_resp is discarded. Latch 0 gets vin=0 and the PC is not advanced (PC already holds the target). On that response → F_RUN. imem_read stays 1.
  - A second br while in F_KILL stays in F_KILL and reloads the PC.
- valid_q[k] updates to latch_vin[k] only when latch_load[k]=1.
- Simultaneous br & lu: br wins; the load-use victim is flushed anyway.
- Simultaneous dstall & br: br is deferred until dstall clears (branch_taken must be held by its source).
- All outputs other than valid_q are combinational from state and inputs.

Optional Feature:
- PERF_CNT_EN defined: adds 32-bit outputs stall_cycles and flush_events.
  - stall_cycles increments on any dstall/lu/fetch-stall cycle.
  - flush_events increments per br.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- PERF_CNT_EN undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset mid-run with valid_q=4'b1111 → valid_q=0 immediately. One cycle after deassert: imem_read=1, latch_load=4'b1111, latch_vin=4'b0001.
- Steady fetch with imem_resp=1 for 4 cycles → valid_q fills 0001,0011,0111,1111; pc_load=1, pc_sel=0 each cycle.
- mem_op=1 with valid_q[2]=1, mem_resp low for 3 cycles → latch_load=4'b1000 with latch_vin[3]=0 for 3 cycles, then normal advance.
- ex_is_load=1, ex_dr=3, id_sr1=3, id_sr1_use=1 → one cycle with pc_load=0, latch_load=4'b1110, latch_vin[1]=0; next cycle normal.
- branch_taken with valid_q[2]=1 while imem_resp=0 → pc_load=1, pc_sel=1, latch_vin[2:0]=0, FSM F_KILL. Next imem_resp gives latch_vin[0]=0, and the following response gives latch_vin[0]=1.
- PERF_CNT_EN: 3 dstall cycles plus 1 branch → stall_cycles=3, flush_events=1.
